// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS-32 core: opcode and funct
// encodings, ALU control codes, FSM state encodings and the immediate
// sign-extension helper.
package mips_pkg;

   localparam logic [5:0] OP_R_TYPE = 6'b000000;
   localparam logic [5:0] OP_LW     = 6'b100011;
   localparam logic [5:0] OP_SW     = 6'b101011;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_J      = 6'b000010;
   localparam logic [5:0] OP_HALT   = 6'b111111;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_NOR = 6'b100111;
   localparam logic [5:0] FN_SLT = 6'b101010;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_NOR = 3'd4,
      ALU_SLT = 3'd5
   } alu_ctl_t;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXECUTE   = 4'd6,
      S_ALU_WB    = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_HALT      = 4'd10
   } state_t;

   function automatic logic [31:0] sext16(input logic [15:0] imm);
      return {{16{imm[15]}}, imm};
   endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational 32-bit ALU shared by every datapath state of the core.
// Ports:
//   a, b     : operands
//   alu_ctl  : operation select (mips_pkg::alu_ctl_t)
//   result   : operation result; ADD/SUB wrap silently
//   zero     : result == 0 (used for BEQ compare via SUB)
module mips_alu
   import mips_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  alu_ctl_t    alu_ctl,
   output logic [31:0] result,
   output logic        zero
);

   always_comb begin
      result = '0;
      case (alu_ctl)
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_NOR: result = ~(a | b);
         ALU_SLT: result = {31'b0, $signed(a) < $signed(b)};
         default: result = '0;
      endcase
   end

   assign zero = (result == 32'd0);

endmodule

// File: rtl/mips_multi_cycle_32.sv
// Multi-cycle MIPS-32 core with one unified word-addressed memory and one
// shared ALU. Register file (reg_file) and memory (memory) are inline arrays
// so a bench can preload them hierarchically.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   pc       : current program counter (word address)
//   state    : current FSM state encoding
//   retire   : one-cycle pulse on the last cycle of each completed instruction
//   halted   : sticky, set on entry to HALT
//   illegal  : sticky, set when HALT was caused by an unsupported encoding
//
// state      | meaning
// -----------+----------------------------------------------------
// FETCH      | IR <= mem[pc], pc <= pc+1
// DECODE     | A/B <= r[rs]/r[rt], ALUOut <= pc+sext(imm) (branch target)
// MEM_ADDR   | ALUOut <= A+sext(imm)
// MEM_READ   | MDR <= mem[ALUOut]
// MEM_WB     | r[rt] <= MDR, retire
// MEM_WRITE  | mem[ALUOut] <= B, retire
// EXECUTE    | ALUOut <= A op B, or HALT on unknown funct
// ALU_WB     | r[rd] <= ALUOut, retire
// BRANCH     | pc <= ALUOut if A==B, retire
// JUMP       | pc <= {pc[31:26], IR[25:0]}, retire
// HALT       | terminal until reset
module mips_multi_cycle_32
   import mips_pkg::*;
#(
   parameter int          MEM_DEPTH      = 256,
   parameter logic [31:0] RESET_PC       = 32'd0,
   parameter bit          REG_INIT_INDEX = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] pc,
   output logic [3:0]  state,
   output logic        retire,
   output logic        halted,
   output logic        illegal
);

   localparam int ADDR_W = $clog2(MEM_DEPTH);

   logic [31:0] memory   [MEM_DEPTH];
   logic [31:0] reg_file [32];

   state_t      state_q, state_d;
   logic [31:0] pc_q, ir_q, mdr_q, a_q, b_q, alu_out_q;
   logic        halted_q, illegal_q;
   logic        halt_set, illegal_set, retire_c;

   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd;
   logic [31:0] imm_ext;

   logic [31:0] alu_a, alu_b, alu_result;
   alu_ctl_t    alu_ctl, funct_ctl;
   logic        alu_zero, funct_ok;

   logic [ADDR_W-1:0] mem_idx;
   logic [31:0]       mem_rdata;
   logic [31:0]       rs_val, rt_val;

   assign opcode  = ir_q[31:26];
   assign rs      = ir_q[25:21];
   assign rt      = ir_q[20:16];
   assign rd      = ir_q[15:11];
   assign funct   = ir_q[5:0];
   assign imm_ext = sext16(ir_q[15:0]);

   assign rs_val = (rs == 5'd0) ? 32'd0 : reg_file[rs];
   assign rt_val = (rt == 5'd0) ? 32'd0 : reg_file[rt];

   // Only FETCH addresses memory by pc; every data access uses ALUOut.
   assign mem_idx   = (state_q == S_FETCH) ? pc_q[ADDR_W-1:0] : alu_out_q[ADDR_W-1:0];
   assign mem_rdata = memory[mem_idx];

   always_comb begin
      funct_ok  = 1'b1;
      funct_ctl = ALU_ADD;
      case (funct)
         FN_ADD:  funct_ctl = ALU_ADD;
         FN_SUB:  funct_ctl = ALU_SUB;
         FN_AND:  funct_ctl = ALU_AND;
         FN_OR:   funct_ctl = ALU_OR;
         FN_NOR:  funct_ctl = ALU_NOR;
         FN_SLT:  funct_ctl = ALU_SLT;
         default: funct_ok  = 1'b0;
      endcase
   end

   // Operand muxes: the default (pc + 1) serves FETCH.
   always_comb begin
      alu_a   = pc_q;
      alu_b   = 32'd1;
      alu_ctl = ALU_ADD;
      case (state_q)
         S_DECODE: begin
            alu_b = imm_ext;
         end
         S_MEM_ADDR: begin
            alu_a = a_q;
            alu_b = imm_ext;
         end
         S_EXECUTE: begin
            alu_a   = a_q;
            alu_b   = b_q;
            alu_ctl = funct_ctl;
         end
         S_BRANCH: begin
            alu_a   = a_q;
            alu_b   = b_q;
            alu_ctl = ALU_SUB;
         end
         default: ;
      endcase
   end

   mips_alu u_alu (
      .a       (alu_a),
      .b       (alu_b),
      .alu_ctl (alu_ctl),
      .result  (alu_result),
      .zero    (alu_zero)
   );

   always_comb begin
      state_d     = state_q;
      halt_set    = 1'b0;
      illegal_set = 1'b0;
      retire_c    = 1'b0;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEM_ADDR;
               OP_R_TYPE:    state_d = S_EXECUTE;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               OP_HALT: begin
                  state_d  = S_HALT;
                  halt_set = 1'b1;
               end
               default: begin
                  state_d     = S_HALT;
                  illegal_set = 1'b1;
               end
            endcase
         end
         S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         S_MEM_READ: state_d = S_MEM_WB;
         S_MEM_WB: begin
            state_d  = S_FETCH;
            retire_c = 1'b1;
         end
         S_MEM_WRITE: begin
            state_d  = S_FETCH;
            retire_c = 1'b1;
         end
         S_EXECUTE: begin
            if (funct_ok) begin
               state_d = S_ALU_WB;
            end else begin
               state_d     = S_HALT;
               illegal_set = 1'b1;
            end
         end
         S_ALU_WB, S_BRANCH, S_JUMP: begin
            state_d  = S_FETCH;
            retire_c = 1'b1;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_HALT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         pc_q      <= RESET_PC;
         ir_q      <= '0;
         mdr_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         alu_out_q <= '0;
         halted_q  <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         halted_q  <= halted_q | halt_set | illegal_set;
         illegal_q <= illegal_q | illegal_set;
         case (state_q)
            S_FETCH: begin
               ir_q <= mem_rdata;
               pc_q <= alu_result;
            end
            S_DECODE: begin
               a_q       <= rs_val;
               b_q       <= rt_val;
               alu_out_q <= alu_result;
            end
            S_MEM_ADDR: alu_out_q <= alu_result;
            S_MEM_READ: mdr_q     <= mem_rdata;
            S_EXECUTE:  alu_out_q <= alu_result;
            S_BRANCH: begin
               if (alu_zero) pc_q <= alu_out_q;
            end
            S_JUMP: pc_q <= {pc_q[31:26], ir_q[25:0]};
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            reg_file[i] <= REG_INIT_INDEX ? 32'(i) : 32'd0;
         end
      end else if (state_q == S_MEM_WB && rt != 5'd0) begin
         reg_file[rt] <= mdr_q;
      end else if (state_q == S_ALU_WB && rd != 5'd0) begin
         reg_file[rd] <= alu_out_q;
      end
   end

   // Memory contents survive reset; only the write is suppressed.
   always_ff @(posedge clk) begin
      if (!rst && state_q == S_MEM_WRITE) begin
         memory[mem_idx] <= b_q;
      end
   end

   assign pc      = pc_q;
   assign state   = state_q;
   assign retire  = retire_c & ~rst;
   assign halted  = halted_q;
   assign illegal = illegal_q;

endmodule

// File: tb/tb_mips_multi_cycle_32.sv
module tb_mips_multi_cycle_32;

   localparam logic [5:0] T_LW   = 6'b100011;
   localparam logic [5:0] T_SW   = 6'b101011;
   localparam logic [5:0] T_BEQ  = 6'b000100;
   localparam logic [5:0] T_ADD  = 6'b100000;
   localparam logic [5:0] T_SUB  = 6'b100010;
   localparam logic [5:0] T_AND  = 6'b100100;
   localparam logic [5:0] T_OR   = 6'b100101;
   localparam logic [5:0] T_NOR  = 6'b100111;
   localparam logic [5:0] T_SLT  = 6'b101010;
   localparam logic [31:0] HALT_W = 32'hFC00_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc;
   logic [3:0]  state;
   logic        retire, halted, illegal;

   mips_multi_cycle_32 #(
      .MEM_DEPTH(256), .RESET_PC(32'd0), .REG_INIT_INDEX(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .pc(pc), .state(state),
      .retire(retire), .halted(halted), .illegal(illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [31:0] pc;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   int          retire_cnt = 0;
   bit          pend    = 1'b0;
   logic [31:0] pend_pc;

   function automatic logic [31:0] r_ins(int rs, int rt, int rd, logic [5:0] fn);
      return {6'b0, 5'(rs), 5'(rt), 5'(rd), 5'b0, fn};
   endfunction

   function automatic logic [31:0] i_ins(logic [5:0] op, int rs, int rt, logic [15:0] imm);
      return {op, 5'(rs), 5'(rt), imm};
   endfunction

   function automatic logic [31:0] j_ins(int target);
      return {6'b000010, 26'(target)};
   endfunction

   // Monitor: on each retire pulse pop the expected cycle/pc-after and compare.
   always @(negedge clk) begin
      if (pend) begin
         n_tests++;
         if (pc !== pend_pc) begin
            n_fail++;
            $display("FAIL retire_pc: got %h want %h", pc, pend_pc);
         end
         pend = 1'b0;
      end
      if (rst) cyc = 0;
      else     cyc++;
      if (retire === 1'b1) begin
         retire_cnt++;
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_retire: got retire at cycle %0d pc %h want none", cyc, pc);
         end else begin
            mon_e = exp_q.pop_front();
            if (cyc != mon_e.cyc) begin
               n_fail++;
               $display("FAIL retire_cycle: got %0d want %0d", cyc, mon_e.cyc);
            end
            pend    = 1'b1;
            pend_pc = mon_e.pc;
         end
      end
   end

   task automatic check(string name, logic [31:0] got, logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic expect_retire(int c, logic [31:0] p);
      exp_t e;
      e.cyc = c;
      e.pc  = p;
      exp_q.push_back(e);
   endtask

   task automatic begin_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      for (int i = 0; i < 256; i++) dut.memory[i] = 32'd0;
      exp_q.delete();
      retire_cnt = 0;
      pend = 1'b0;
   endtask

   task automatic wait_halt(string name, int budget);
      for (int i = 0; i < budget; i++) begin
         if (halted === 1'b1) break;
         @(posedge clk); #1;
      end
      check({name, "_halted"}, {31'b0, halted}, 32'd1);
      @(posedge clk); #1;
      check({name, "_queue_left"}, exp_q.size(), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;

      // ---- reset state ----
      begin_reset();
      check("rst_pc", pc, 32'd0);
      check("rst_state", {28'b0, state}, 32'd0);
      check("rst_halted", {31'b0, halted}, 32'd0);
      check("rst_illegal", {31'b0, illegal}, 32'd0);
      check("rst_r5", dut.reg_file[5], 32'd5);

      // ---- ADD/SUB with loads and stores ----
      dut.memory[0]  = i_ins(T_LW, 0, 1, 16'd40);
      dut.memory[1]  = i_ins(T_LW, 0, 2, 16'd30);
      dut.memory[2]  = r_ins(1, 2, 3, T_ADD);
      dut.memory[3]  = i_ins(T_SW, 0, 3, 16'd50);
      dut.memory[4]  = r_ins(1, 2, 4, T_SUB);
      dut.memory[5]  = i_ins(T_SW, 0, 4, 16'd51);
      dut.memory[6]  = HALT_W;
      dut.memory[40] = 32'd40;
      dut.memory[30] = 32'd30;
      expect_retire(5, 1);  expect_retire(10, 2); expect_retire(14, 3);
      expect_retire(18, 4); expect_retire(22, 5); expect_retire(26, 6);
      rst = 1'b0;
      wait_halt("addsub", 100);
      check("addsub_mem50", dut.memory[50], 32'd70);
      check("addsub_mem51", dut.memory[51], 32'd10);
      check("addsub_retires", retire_cnt, 32'd6);
      check("addsub_pc", pc, 32'd7);
      check("addsub_illegal", {31'b0, illegal}, 32'd0);

      // ---- logic ops and signed SLT ----
      begin_reset();
      dut.memory[0]  = r_ins(1, 2, 3, T_AND);
      dut.memory[1]  = r_ins(1, 2, 4, T_OR);
      dut.memory[2]  = r_ins(1, 2, 5, T_NOR);
      dut.memory[3]  = r_ins(1, 2, 6, T_SLT);
      dut.memory[4]  = r_ins(2, 1, 7, T_SLT);
      dut.memory[5]  = r_ins(10, 11, 12, T_SLT);
      dut.memory[6]  = i_ins(T_SW, 0, 3, 16'd60);
      dut.memory[7]  = i_ins(T_SW, 0, 4, 16'd61);
      dut.memory[8]  = i_ins(T_SW, 0, 5, 16'd62);
      dut.memory[9]  = i_ins(T_SW, 0, 6, 16'd63);
      dut.memory[10] = i_ins(T_SW, 0, 7, 16'd64);
      dut.memory[11] = i_ins(T_SW, 0, 12, 16'd65);
      dut.memory[12] = HALT_W;
      for (int k = 0; k < 6; k++)  expect_retire(4 * (k + 1), k + 1);
      for (int k = 6; k < 12; k++) expect_retire(24 + 4 * (k - 5), k + 1);
      rst = 1'b0;
      dut.reg_file[1]  = 32'd22;
      dut.reg_file[2]  = 32'd12;
      dut.reg_file[10] = 32'hFFFF_FFFF;
      dut.reg_file[11] = 32'd1;
      wait_halt("logic", 150);
      check("logic_and", dut.memory[60], 32'd4);
      check("logic_or",  dut.memory[61], 32'd30);
      check("logic_nor", dut.memory[62], 32'hFFFF_FFE1);
      check("slt_12_lt", dut.memory[63], 32'd0);
      check("slt_21_lt", dut.memory[64], 32'd1);
      check("slt_signed", dut.memory[65], 32'd1);

      // ---- J, BEQ taken with negative offset, BEQ not taken ----
      begin_reset();
      dut.memory[0]  = j_ins(10);
      dut.memory[10] = i_ins(T_BEQ, 1, 1, 16'hFFFD);
      dut.memory[8]  = i_ins(T_BEQ, 1, 2, 16'd5);
      dut.memory[9]  = HALT_W;
      expect_retire(3, 10);
      expect_retire(6, 8);
      expect_retire(9, 9);
      rst = 1'b0;
      wait_halt("beq", 60);
      check("beq_pc", pc, 32'd10);
      check("beq_retires", retire_cnt, 32'd3);

      // ---- J then HALT, state frozen ----
      begin_reset();
      dut.memory[0]  = j_ins(5);
      dut.memory[5]  = j_ins(20);
      dut.memory[20] = HALT_W;
      expect_retire(3, 5);
      expect_retire(6, 20);
      rst = 1'b0;
      wait_halt("jump", 60);
      check("jump_pc", pc, 32'd21);
      check("jump_illegal", {31'b0, illegal}, 32'd0);
      repeat (10) @(posedge clk);
      #1;
      check("frozen_pc", pc, 32'd21);
      check("frozen_state", {28'b0, state}, 32'd10);
      check("frozen_retires", retire_cnt, 32'd2);

      // ---- illegal opcode ----
      begin_reset();
      dut.memory[0] = i_ins(6'b001000, 1, 2, 16'd5);
      rst = 1'b0;
      wait_halt("ill_op", 30);
      check("ill_op_flag", {31'b0, illegal}, 32'd1);
      check("ill_op_pc", pc, 32'd1);
      check("ill_op_r2", dut.reg_file[2], 32'd2);
      check("ill_op_retires", retire_cnt, 32'd0);

      // ---- illegal funct: no register write ----
      begin_reset();
      dut.memory[0] = r_ins(1, 2, 3, 6'b000000);
      rst = 1'b0;
      wait_halt("ill_fn", 30);
      check("ill_fn_flag", {31'b0, illegal}, 32'd1);
      check("ill_fn_r3", dut.reg_file[3], 32'd3);
      check("ill_fn_state", {28'b0, state}, 32'd10);

      // ---- reset during MEM_READ, then r0 write attempt ----
      begin_reset();
      dut.memory[0]  = i_ins(T_LW, 0, 5, 16'd40);
      dut.memory[40] = 32'h0000_DEAD;
      rst = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(posedge clk); #1;
         if (state == 4'd3) found = 1'b1;
      end
      check("reach_mem_read", {31'b0, found}, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_state", {28'b0, state}, 32'd0);
      check("midrst_pc", pc, 32'd0);
      check("midrst_r5", dut.reg_file[5], 32'd5);
      check("midrst_retires", retire_cnt, 32'd0);
      dut.memory[0] = r_ins(1, 2, 0, T_ADD);
      dut.memory[1] = HALT_W;
      expect_retire(4, 1);
      rst = 1'b0;
      wait_halt("r0", 40);
      check("r0_zero", dut.reg_file[0], 32'd0);
      check("r0_illegal", {31'b0, illegal}, 32'd0);
      check("r5_kept", dut.reg_file[5], 32'd5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
